// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters in bursts of up to BURST_LEN beats.
// Optional FIFO_ARB_BEAT_CNT_EN adds a saturating 16-bit count of FIFO writes on port beat_total.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned IDW       = 2,
    parameter int unsigned DW        = 4,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 fifo_winc,
    output logic [DW-1:0]        fifo_wdata,
    input  logic                 fifo_wfull,
    input  logic                 fifo_prog_full,
    output logic [IDW-1:0]       gnt_id,
    output logic                 busy
`ifdef FIFO_ARB_BEAT_CNT_EN
    ,
    output logic [15:0]          beat_total
`endif
);

    localparam int unsigned CW = 8;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [IDW-1:0]  gnt_q, gnt_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  sel_idx;
    logic [IDW-1:0]  cand;
    logic            sel_found;
    logic            gnt_valid;

    assign gnt_id    = gnt_q;
    assign busy      = (state_q == BURST);
    assign gnt_valid = ((req_valid >> gnt_q) & NREQ'(1)) != '0;

    // First valid requester after the last grant, wrapping modulo NREQ
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDW'((32'(last_q) + i) % NREQ);
            if (!sel_found && (((req_valid >> cand) & NREQ'(1)) != '0)) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            beat_q  <= '0;
            gnt_q   <= '0;
            last_q  <= IDW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Write path is gated by rstn so a reset cycle never commits a partial beat
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        req_ready  = '0;
        fifo_winc  = 1'b0;
        fifo_wdata = '0;
        case (state_q)
            IDLE: begin
                if (sel_found && !fifo_prog_full) begin
                    gnt_d   = sel_idx;
                    last_d  = sel_idx;
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (rstn) begin
                    fifo_wdata = DW'(req_data >> (32'(gnt_q) * DW));
                    if (!fifo_wfull) begin
                        req_ready = NREQ'(1) << gnt_q;
                        if (gnt_valid) begin
                            fifo_winc = 1'b1;
                            beat_d    = beat_q + CW'(1);
                            if (beat_q == CW'(BURST_LEN - 1)) begin
                                state_d = IDLE;
                            end
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FIFO_ARB_BEAT_CNT_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_total <= '0;
        end else if (fifo_winc && (beat_total != 16'hFFFF)) begin
            beat_total <= beat_total + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one FIFO write interface among NREQ requesters.
- Sits in the FIFO write-clock domain, between the requesters and the FIFO's winc/wdata/wfull/prog_full pins.
- Grants one requester at a time for a burst of up to BURST_LEN beats.
- Respects full (stall) and prog_full (no new grants).

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of gnt_id; must satisfy 2**IDW >= NREQ.
- DW, 4, data width; equals the FIFO write data width.
- BURST_LEN, 8, maximum beats per grant (1..255).

Ports:
- clk  in  1  write-side clock; all logic on rising edge.
- rstn  in  1  synchronous active-low reset, sampled on rising clk.
- req_valid  in  NREQ  per-requester data valid.
- req_data  in  NREQ*DW  requester i data at bits [i*DW +: DW].
- req_ready  out  NREQ  per-requester accept; a beat transfers when valid&ready.
- fifo_winc  out  1  FIFO write enable.
- fifo_wdata  out  DW  FIFO write data.
- fifo_wfull  in  1  FIFO full flag.
- fifo_prog_full  in  1  FIFO programmable-full flag.
- gnt_id  out  IDW  index of the current or last granted requester.
- busy  out  1  high while in BURST state.

Behaviour:
- Reset (rstn low at a clk edge):
  - state=IDLE, beat_cnt=0, gnt_id=0, last_gnt=NREQ-1, so the first grant goes to requester 0.
  - All req_ready=0, fifo_winc=0, busy=0.
  - Reset mid-burst drops the burst immediately; no partial beat is written on the reset cycle.
- States: IDLE, BURST.
- IDLE:
  - If any req_valid and !fifo_prog_full: select the first valid index searching last_gnt+1, last_gnt+2, ... modulo NREQ.
  - Register the selection into gnt_id and last_gnt, clear beat_cnt, go to BURST.
  - Otherwise stay in IDLE.
  - The arbitration decision costs exactly 1 cycle; no beat is accepted in IDLE.
- BURST:
  - req_ready[gnt_id] = !fifo_wfull; every other req_ready bit is 0.
  - Beat accepted = req_valid[gnt_id] & req_ready[gnt_id].
  - fifo_winc = beat accepted, combinational, zero latency.
  - fifo_wdata = req_data slice for gnt_id, always driven in BURST. In IDLE fifo_wdata=0.
  - Each accepted beat increments beat_cnt (8-bit).
- BURST exit to IDLE at the clk edge where either condition holds:
  - (a) a beat is accepted with beat_cnt==BURST_LEN-1, or
  - (b) req_valid[gnt_id]==0 while fifo_wfull==0 (requester ran dry).
- fifo_wfull high in BURST:
  - Stall: no beat, stay in BURST, beat_cnt held.
  - Condition (b) is not evaluated while full.
- fifo_prog_full rising during BURST: the burst continues to completion. prog_full only gates new grants in IDLE.
- Simultaneous valid from all requesters with continuous traffic: grants rotate 0,1,2,3,0,...
  - Each grant delivers BURST_LEN beats.
  - One IDLE cycle separates consecutive bursts.
- gnt_id holds its value through IDLE until the next grant.
- The FIFO is never written when fifo_wfull=1: fifo_winc can only be high when req_ready is high, and req_ready requires !fifo_wfull.

Optional Feature:
- Macro FIFO_ARB_BEAT_CNT_EN.
- Defined:
  - Adds output port beat_total [15:0], reset 0.
  - Increments by 1 on every fifo_winc cycle.
  - Saturates at 16'hFFFF; does not wrap.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then req_valid=4'b0001 continuously, prog_full=0, wfull=0 -> IDLE 1 cycle, then 8 consecutive fifo_winc pulses with gnt_id=0, 1 IDLE cycle, next burst also gnt_id=0.
- req_valid=4'b1111 held, no backpressure -> bursts granted to 0,1,2,3,0; each burst is 8 beats; fifo_wdata matches the granted slice each beat.
- Requester 2 alone, wfull asserted after beat 3 for 5 cycles -> no fifo_winc and req_ready[2]=0 during those cycles; beats 4..8 resume after wfull drops; total 8 beats.
- Requester 1 drops valid after 3 beats -> exits to IDLE, busy=0 next cycle. Requester 3 then valid -> grant to 3, not 1 or 2.
- prog_full=1 in IDLE with all valid -> no grant, busy=0. prog_full rises mid-burst -> that burst completes its 8 beats, then no new grant until prog_full=0.
- rstn low for 1 cycle mid-burst at beat 5 -> next cycle state IDLE, gnt_id=0, req_ready=0; the next grant goes to requester 0. With FIFO_ARB_BEAT_CNT_EN, beat_total=0 after reset.
